reg_dump_reader: RTL and testbench

Sequential reader on the register-file read side. On Start it walks R0..R7 through one read port and emits each register selected by a latched mask as a valid/ready beat {OUT_REG, OUT_DATA}. The beats feed the hex-display/debug path. It sits beside the datapath on an SR read port that the datapath releases while the CPU is halted or paused.

---
 rtl/reg_dump_pkg.sv | 23 ++
 rtl/reg_dump_reader.sv | 141 ++++++++++++++
 tb/tb_reg_dump_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_pkg
//  Purpose  : Shared constants and FSM state encoding for reg_dump_reader.
//  Revision : 1.0  initial release
// ============================================================================
package reg_dump_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    // SUM is only reachable when the checksum beat is built in.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        PRESENT = 3'd2,
        DONE    = 3'd3,
        SUM     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader
//  Purpose  : Walks R0..R7 through one register-file read port and emits
//             each register selected by a latched mask as a valid/ready
//             beat {OUT_REG, OUT_DATA} for the debug/hex-display path.
//  Options  : REG_DUMP_CHECKSUM_EN adds OUT_SUM and a trailing XOR
//             checksum beat after the last register.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_reader
    import reg_dump_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [NUM_REGS-1:0] Mask,
    output logic [ADDR_W-1:0]   RD_ADDR,
    input  logic [REG_W-1:0]    RD_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [ADDR_W-1:0]   OUT_REG,
    output logic [REG_W-1:0]    OUT_DATA,
    output logic                Busy,
    output logic                Done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic                OUT_SUM
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [NUM_REGS-1:0] mask_q;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_W-1:0]    acc;
`endif

    // Read port address tracks the scan index; status flags decode the state.
    assign RD_ADDR = idx;
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);

    // Scan FSM and beat output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            mask_q    <= '0;
            OUT_VALID <= 1'b0;
            OUT_REG   <= '0;
            OUT_DATA  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            OUT_SUM   <= 1'b0;
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mask_q <= Mask;
                        idx    <= '0;
                        state  <= SCAN;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc    <= '0;
`endif
                    end
                end

                SCAN: begin
                    if (mask_q[idx]) begin
                        OUT_DATA  <= RD_DATA;
                        OUT_REG   <= idx;
                        OUT_VALID <= 1'b1;
                        state     <= PRESENT;
                    end else if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Final scan with nothing left to send: emit checksum.
                        OUT_DATA  <= acc;
                        OUT_REG   <= '0;
                        OUT_SUM   <= 1'b1;
                        OUT_VALID <= 1'b1;
                        state     <= SUM;
`else
                        state     <= DONE;
`endif
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end

                PRESENT: begin
                    // OUT_VALID is always high here, so READY alone means transfer.
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc <= acc ^ OUT_DATA;
`endif
                        if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            OUT_DATA  <= acc ^ OUT_DATA;
                            OUT_REG   <= '0;
                            OUT_SUM   <= 1'b1;
                            OUT_VALID <= 1'b1;
                            state     <= SUM;
`else
                            state     <= DONE;
`endif
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= SCAN;
                        end
                    end
                end

`ifdef REG_DUMP_CHECKSUM_EN
                SUM: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        OUT_SUM   <= 1'b0;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_reader
//  Purpose  : Directed self-checking bench for reg_dump_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump_reader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [7:0]  Mask;
    logic [2:0]  RD_ADDR;
    logic [15:0] RD_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [2:0]  OUT_REG;
    logic [15:0] OUT_DATA;
    logic        Busy;
    logic        Done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic        OUT_SUM;
`endif

    logic [15:0] regs [0:7];

    int n_checks;
    int n_pass;

    // Collected results of one dump.
    logic [2:0]  beat_reg  [0:15];
    logic [15:0] beat_data [0:15];
    int          nbeats;
    int          ndone;
    int          busy_cycles;
    int          done_at_busy;
    int          done_at_beats;
    int          nsum;
    logic [15:0] sum_val;

    assign RD_DATA = regs[RD_ADDR];

    reg_dump_reader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Mask      (Mask),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_REG   (OUT_REG),
        .OUT_DATA  (OUT_DATA),
        .Busy      (Busy),
        .Done      (Done)
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        .OUT_SUM   (OUT_SUM)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Observe from the current sample point until the DUT is back in IDLE.
    task automatic collect(input int budget);
        int cyc;
        nbeats        = 0;
        ndone         = 0;
        busy_cycles   = 0;
        done_at_busy  = -1;
        done_at_beats = -1;
        nsum          = 0;
        sum_val       = '0;
        cyc           = 0;
        while (Busy && cyc < budget) begin
            busy_cycles++;
            if (OUT_VALID && OUT_READY) begin
`ifdef REG_DUMP_CHECKSUM_EN
                if (OUT_SUM) begin
                    nsum++;
                    sum_val = OUT_DATA;
                end else
`endif
                begin
                    if (nbeats < 16) begin
                        beat_reg[nbeats]  = OUT_REG;
                        beat_data[nbeats] = OUT_DATA;
                    end
                    nbeats++;
                end
            end
            if (Done) begin
                ndone++;
                if (done_at_busy < 0) begin
                    done_at_busy  = busy_cycles;
                    done_at_beats = nbeats;
                end
            end
            step();
            cyc++;
        end
        if (Busy) check("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int cyc;
        cyc = 0;
        while (!OUT_VALID && cyc < budget) begin
            step();
            cyc++;
        end
        if (!OUT_VALID) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Reset     = 1'b1;
        Start     = 1'b0;
        Mask      = 8'h00;
        OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_busy",  32'(Busy),      32'd0);
        check("rst_done",  32'(Done),      32'd0);
        check("rst_addr",  32'(RD_ADDR),   32'd0);
        check("rst_reg",   32'(OUT_REG),   32'd0);
        check("rst_data",  32'(OUT_DATA),  32'd0);
        Reset = 1'b0;
        step();

        // 1: full mask, consumer always ready
        for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
        OUT_READY = 1'b1;
        Mask      = 8'hFF;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        Mask  = 8'h00;
        check("t1_busy",   32'(Busy),      32'd1);
        check("t1_lat1",   32'(OUT_VALID), 32'd0);
        step();
        check("t1_lat2",   32'(OUT_VALID), 32'd1);
        check("t1_first",  32'(OUT_DATA),  32'h1000);
        collect(100);
        check("t1_nbeats", 32'(nbeats), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t1_reg",  32'(beat_reg[i]),  32'(i));
            check("t1_data", 32'(beat_data[i]), 32'h1000 + 32'(i));
        end
        check("t1_ndone",      32'(ndone),         32'd1);
        check("t1_done_after", 32'(done_at_beats), 32'd8);
        check("t1_idle_done",  32'(Done),          32'd0);

        // 2: sparse mask with back-pressure on the first beat
        regs[0]   = 16'hBEEF;
        regs[7]   = 16'h1234;
        OUT_READY = 1'b0;
        Mask      = 8'h81;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", 32'(OUT_VALID), 32'd1);
            check("t2_hold_data",  32'(OUT_DATA),  32'hBEEF);
            step();
        end
        check("t2_hold6_data", 32'(OUT_DATA), 32'hBEEF);
        OUT_READY = 1'b1;
        collect(100);
        check("t2_nbeats", 32'(nbeats),       32'd2);
        check("t2_b0",     32'(beat_data[0]), 32'hBEEF);
        check("t2_b1_reg", 32'(beat_reg[1]),  32'd7);
        check("t2_b1",     32'(beat_data[1]), 32'h1234);
        check("t2_ndone",  32'(ndone),        32'd1);

        // 3: empty mask
        Mask  = 8'h00;
        Start = 1'b1;
        step();
        Start = 1'b0;
        collect(100);
        check("t3_nbeats", 32'(nbeats), 32'd0);
        check("t3_ndone",  32'(ndone),  32'd1);
`ifdef REG_DUMP_CHECKSUM_EN
        check("t3_busy",   32'(busy_cycles),  32'd10);
        check("t3_nsum",   32'(nsum),         32'd1);
        check("t3_sum",    32'(sum_val),      32'd0);
`else
        check("t3_busy",   32'(busy_cycles),  32'd9);
        check("t3_donecy", 32'(done_at_busy), 32'd9);
`endif

        // 4: Start re-pulsed mid-dump with a different mask
        for (int i = 0; i < 8; i++) regs[i] = 16'h00A0 + 16'(i);
        OUT_READY = 1'b0;
        Mask      = 8'h04;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        wait_valid(20);
        check("t4_reg", 32'(OUT_REG), 32'd2);
        Start = 1'b1;
        Mask  = 8'hFF;
        step();
        step();
        check("t4_hold_reg",   32'(OUT_REG),   32'd2);
        check("t4_hold_valid", 32'(OUT_VALID), 32'd1);
        OUT_READY = 1'b1;
        collect(100);
        check("t4_nbeats", 32'(nbeats),       32'd1);
        check("t4_data",   32'(beat_data[0]), 32'h00A2);
        check("t4_ndone",  32'(ndone),        32'd1);
        check("t4_idle",   32'(Busy),         32'd0);
        step();
        check("t4_restart", 32'(Busy), 32'd1);
        Start = 1'b0;
        Mask  = 8'h00;
        collect(100);
        check("t4_nbeats2", 32'(nbeats), 32'd8);

        // 5: asynchronous reset while a beat is pending
        OUT_READY = 1'b0;
        regs[3]   = 16'h5A5A;
        Mask      = 8'h08;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        wait_valid(20);
        check("t5_pre_addr", 32'(RD_ADDR),  32'd3);
        check("t5_pre_data", 32'(OUT_DATA), 32'h5A5A);
        #2;
        Reset = 1'b1;
        #1;
        check("t5_valid", 32'(OUT_VALID), 32'd0);
        check("t5_busy",  32'(Busy),      32'd0);
        check("t5_addr",  32'(RD_ADDR),   32'd0);
        check("t5_data",  32'(OUT_DATA),  32'd0);
        check("t5_done",  32'(Done),      32'd0);
        step();
        check("t5_done2", 32'(Done), 32'd0);
        Reset = 1'b0;
        step();
        check("t5_idle", 32'(Busy), 32'd0);

`ifdef REG_DUMP_CHECKSUM_EN
        // 6: checksum beat
        regs[0]   = 16'h00FF;
        regs[1]   = 16'h0F0F;
        OUT_READY = 1'b1;
        Mask      = 8'h03;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        collect(100);
        check("t6_nbeats", 32'(nbeats),       32'd2);
        check("t6_b0",     32'(beat_data[0]), 32'h00FF);
        check("t6_b1",     32'(beat_data[1]), 32'h0F0F);
        check("t6_nsum",   32'(nsum),         32'd1);
        check("t6_sum",    32'(sum_val),      32'h0FF0);
        check("t6_ndone",  32'(ndone),        32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
